// File: rtl/dest_fwd_pipe.sv
// dest_fwd_pipe: carries the EX-stage destination register and its write/load
// flags through the MEM and WB pipeline registers. From that state it derives
// the EX operand forwarding selects and the ID-stage load-use stall request.
// It also keeps a saturating count of the cycles spent in load-use stall.
module dest_fwd_pipe #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              flush,
  input  logic [ADDR_W-1:0] ex_dest,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic [ADDR_W-1:0] ex_rs,
  input  logic [ADDR_W-1:0] ex_rt,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  output logic [ADDR_W-1:0] mem_dest,
  output logic              mem_regwrite,
  output logic              mem_memread,
  output logic [ADDR_W-1:0] wb_dest,
  output logic              wb_regwrite,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              load_use_stall,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  logic [ADDR_W-1:0] mem_dest_q, mem_dest_d;
  logic              mem_regwrite_q, mem_regwrite_d;
  logic              mem_memread_q, mem_memread_d;
  logic [ADDR_W-1:0] wb_dest_q, wb_dest_d;
  logic              wb_regwrite_q, wb_regwrite_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  // MEM/WB next state: hold freezes both stages and wins over flush.
  // A flush puts a bubble into MEM, while WB still takes the old MEM contents.
  always_comb begin
    mem_dest_d     = mem_dest_q;
    mem_regwrite_d = mem_regwrite_q;
    mem_memread_d  = mem_memread_q;
    wb_dest_d      = wb_dest_q;
    wb_regwrite_d  = wb_regwrite_q;
    if (!hold) begin
      wb_dest_d     = mem_dest_q;
      wb_regwrite_d = mem_regwrite_q;
      if (flush) begin
        mem_dest_d     = '0;
        mem_regwrite_d = 1'b0;
        mem_memread_d  = 1'b0;
      end else begin
        mem_dest_d     = ex_dest;
        mem_regwrite_d = ex_regwrite;
        mem_memread_d  = ex_memread;
      end
    end
  end

  // Load-use hazard: a register-writing load in EX feeds a source of the ID instruction.
  always_comb begin
    load_use_stall = ex_memread & ex_regwrite & (ex_dest != '0) &
                     ((ex_dest == id_rs) | (ex_dest == id_rt));
  end

  // Stall counter: counts stalled cycles, saturates at all-ones, ignores hold.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (load_use_stall && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // Pipeline and counter registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_dest_q     <= '0;
      mem_regwrite_q <= 1'b0;
      mem_memread_q  <= 1'b0;
      wb_dest_q      <= '0;
      wb_regwrite_q  <= 1'b0;
      stall_cnt_q    <= '0;
    end else begin
      mem_dest_q     <= mem_dest_d;
      mem_regwrite_q <= mem_regwrite_d;
      mem_memread_q  <= mem_memread_d;
      wb_dest_q      <= wb_dest_d;
      wb_regwrite_q  <= wb_regwrite_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  // Forwarding selects. MEM wins over WB, but a load in MEM has no result yet,
  // so it never forwards and the WB check is used instead. r0 is never forwarded.
  always_comb begin
    fwd_a = FWD_RF;
    if (mem_regwrite_q && !mem_memread_q && (mem_dest_q != '0) && (mem_dest_q == ex_rs))
      fwd_a = FWD_MEM;
    else if (wb_regwrite_q && (wb_dest_q != '0) && (wb_dest_q == ex_rs))
      fwd_a = FWD_WB;

    fwd_b = FWD_RF;
    if (mem_regwrite_q && !mem_memread_q && (mem_dest_q != '0) && (mem_dest_q == ex_rt))
      fwd_b = FWD_MEM;
    else if (wb_regwrite_q && (wb_dest_q != '0) && (wb_dest_q == ex_rt))
      fwd_b = FWD_WB;
  end

  // Registered state driven onto the outputs.
  always_comb begin
    mem_dest     = mem_dest_q;
    mem_regwrite = mem_regwrite_q;
    mem_memread  = mem_memread_q;
    wb_dest      = wb_dest_q;
    wb_regwrite  = wb_regwrite_q;
    stall_cnt    = stall_cnt_q;
  end

endmodule

// File: doc/dest_fwd_pipe.md
Name: dest_fwd_pipe

Overview:
- Consumes the 5-bit destination-register number chosen by the EX-stage rt/rd select, together with its write/load control bits.
- Carries them through the MEM and WB pipeline registers.
- From that pipelined state it generates the EX-stage operand forwarding selects and the ID-stage load-use stall request for the 5-stage pipeline.
- Sits between the destination-register select and the register file write port and hazard logic.

Parameters:
ADDR_W, 5, register-number width. Register 0 is the hardwired zero register.
CNT_W, 16, width of the saturating load-use stall counter.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
hold  input  1  freezes the MEM and WB registers (memory wait)
flush  input  1  inserts a bubble into MEM in place of the EX instruction
ex_dest  input  ADDR_W  destination register of the instruction in EX (select output)
ex_regwrite  input  1  EX instruction writes the register file
ex_memread  input  1  EX instruction is a load
ex_rs  input  ADDR_W  source A of the EX instruction
ex_rt  input  ADDR_W  source B of the EX instruction
id_rs  input  ADDR_W  source A of the ID instruction
id_rt  input  ADDR_W  source B of the ID instruction
mem_dest  output  ADDR_W  registered MEM-stage destination
mem_regwrite  output  1  registered MEM-stage write enable
mem_memread  output  1  registered MEM-stage load flag
wb_dest  output  ADDR_W  registered WB-stage destination (register file write address)
wb_regwrite  output  1  registered WB-stage write enable (register file we)
fwd_a  output  2  operand A select: 00 regfile, 10 MEM result, 01 WB result
fwd_b  output  2  operand B select, same encoding
load_use_stall  output  1  stall request for IF/ID; bubble into EX
stall_cnt  output  CNT_W  cycles in which load_use_stall was 1, saturating

Behaviour:
Reset:
- rst=1 forces, asynchronously, all of these to 0: mem_dest, mem_regwrite, mem_memread, wb_dest, wb_regwrite and stall_cnt.
- fwd_a and fwd_b therefore read 00.
- load_use_stall is combinational from the ex_* and id_* inputs. It is 0 whenever ex_memread=0.

Pipeline update (rising clk, rst=0):
- hold=1: MEM and WB registers keep their values. hold has priority over flush.
- hold=0, flush=0: MEM takes ex_dest, ex_regwrite and ex_memread. WB takes mem_dest and mem_regwrite.
- hold=0, flush=1: MEM takes dest=0, regwrite=0, memread=0. WB still takes the old MEM contents.
- Latency: 1 cycle from EX inputs to mem_*, 2 cycles to wb_*.

Forwarding (combinational from registered state and ex_rs/ex_rt), shown for fwd_a; fwd_b is identical using ex_rt:
- 10 if mem_regwrite=1, mem_memread=0, mem_dest!=0 and mem_dest==ex_rs.
- Otherwise 01 if wb_regwrite=1, wb_dest!=0 and wb_dest==ex_rs.
- Otherwise 00.
- MEM has priority over WB when both match.
- A matching load in MEM never yields 10. The load-use stall makes this case unreachable; when it does occur it falls through to the WB check.
- Register 0 is never forwarded.

Load-use stall:
- load_use_stall = ex_memread & ex_regwrite & (ex_dest!=0) & ((ex_dest==id_rs) | (ex_dest==id_rt)).
- It is purely combinational and is not gated by hold or flush.

Stall counter:
- Increments on each rising clk where load_use_stall=1 and rst=0.
- Holds at all-ones. It is not affected by hold.

Reset mid-operation:
- Takes effect immediately with no clock required.
- Any in-flight destinations are discarded and fwd_a and fwd_b drop to 00 in the same cycle.

Test Plan:
- Assert rst while the MEM and WB registers hold nonzero values, with no clock edge → all registered outputs are 0 and fwd_a=fwd_b=00 immediately. Release rst → values stay 0 until the next edge.
- ALU back-to-back: cycle 0 ex_dest=8, ex_regwrite=1. Cycle 1 ex_rs=8, ex_rt=8 → fwd_a=fwd_b=10. Cycle 2 ex_rs=8 → fwd_a=01, wb_dest=8, wb_regwrite=1.
- Priority and zero register: MEM dest=5 and WB dest=5 both writing, ex_rs=5 → fwd_a=10. Dest=0 with regwrite=1 and ex_rs=0 → fwd_a=00.
- Load-use: ex_memread=1, ex_regwrite=1, ex_dest=9, id_rt=9 → load_use_stall=1 in the same cycle and stall_cnt increments by 1 at the edge. The same stimulus with id_rs=id_rt=0 and ex_dest=0 → load_use_stall=0.
- hold and flush: with MEM dest=3, assert hold=1 and flush=1 for 2 edges → MEM and WB unchanged. Then hold=0, flush=1 → mem_regwrite=0, mem_dest=0, and wb_dest takes 3.
- Counter saturation: with CNT_W=4, hold load_use_stall=1 for 20 edges → stall_cnt=15 and stays at 15.
